// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Purpose:
//   Generic handshaked pipeline-stage register with a two-entry skid buffer.
//   It carries a wide payload (DATA_W) and a control field (CTRL_W). The
//   control field is zeroed whenever an entry is invalidated (bubble or flush)
//   so that downstream write-enables can never fire from a stale entry.
//   in_ready is a function of the state register only, so the backpressure
//   seen upstream is registered. One entry per cycle is sustained when
//   downstream keeps accepting.
//
// Optional feature:
//   Define PIPE_STAGE_BUF_PERF_EN to build the saturating stall/bubble
//   performance counters. Without it, stall_cnt and bubble_cnt are tied to
//   zero and no counter flops exist.
//
// Ports:
//   CLK        in   1       clock, rising edge
//   RST        in   1       asynchronous, active-high reset
//   in_valid   in   1       upstream entry present
//   in_ready   out  1       stage can accept (state register only)
//   in_ctrl    in   CTRL_W  upstream control bits
//   in_data    in   DATA_W  upstream payload
//   flush      in   1       squash all held entries
//   hold       in   1       external stall; blocks drain only
//   out_valid  out  1       head entry valid
//   out_ready  in   1       downstream accepts head
//   out_ctrl   out  CTRL_W  head control; 0 when out_valid = 0
//   out_data   out  DATA_W  head payload; keeps last value when invalid
//   occupancy  out  2       entries held (0..2)
//   stall_cnt  out  CNT_W   cycles with head valid but not drained
//   bubble_cnt out  CNT_W   cycles with out_valid = 0
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W = 256,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;

  logic accept;
  logic drain;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready & ~hold;

  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  always_comb begin
    unique case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and storage update.
  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Squash both entries; payload is left in place (only ctrl matters for
      // side effects). A drain in this same cycle is already consumed.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers are reset too, because out_data must read 0
  // straight out of reset; for wide data this costs reset fan-out, not logic.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             stall_evt;
  logic             bubble_evt;

  assign stall_evt  = out_valid & (~out_ready | hold);
  assign bubble_evt = ~out_valid;

  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bubble_evt && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed, table-driven bench for pipe_stage_buf. Each table record holds the
// inputs for one clock cycle and the outputs expected just after that edge.
// Hand-written sequences cover asynchronous reset and the perf counters.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int DATA_W = 256;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 32;

  logic              CLK;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              hold;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .hold       (hold),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        flush;
    logic        hold;
    logic        out_ready;
    logic        exp_valid;
    logic [15:0] exp_ctrl;
    logic [31:0] exp_data;
    logic [1:0]  exp_occ;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic iv, logic [15:0] ic,
                              logic [31:0] id, logic fl, logic hd, logic ordy,
                              logic ev, logic [15:0] ec, logic [31:0] ed,
                              logic [1:0] eo, logic er);
    vec_t r;
    r.name = name;      r.in_valid = iv;  r.in_ctrl = ic;  r.in_data = id;
    r.flush = fl;       r.hold = hd;      r.out_ready = ordy;
    r.exp_valid = ev;   r.exp_ctrl = ec;  r.exp_data = ed;
    r.exp_occ = eo;     r.exp_rdy = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ic,
                       input logic [31:0] id, input logic fl, input logic hd,
                       input logic ordy);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = DATA_W'(id);
    flush     = fl;
    hold      = hd;
    out_ready = ordy;
  endtask

  // Apply inputs mid-low-phase, then sample 1 time unit after the rising edge.
  task automatic step(input vec_t x);
    @(negedge CLK);
    drive(x.in_valid, x.in_ctrl, x.in_data, x.flush, x.hold, x.out_ready);
    @(posedge CLK);
    #1;
    check({x.name, ".out_valid"}, 256'(out_valid), 256'(x.exp_valid));
    check({x.name, ".out_ctrl"},  256'(out_ctrl),  256'(x.exp_ctrl));
    check({x.name, ".out_data"},  256'(out_data),  256'(x.exp_data));
    check({x.name, ".occupancy"}, 256'(occupancy), 256'(x.exp_occ));
    check({x.name, ".in_ready"},  256'(in_ready),  256'(x.exp_rdy));
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst.out_valid", 256'(out_valid), 256'(0));
    check("rst.out_ctrl",  256'(out_ctrl),  256'(0));
    check("rst.out_data",  256'(out_data),  256'(0));
    check("rst.occupancy", 256'(occupancy), 256'(0));
    check("rst.in_ready",  256'(in_ready),  256'(1));
    RST = 1'b0;

    // ---------------- streaming 1..8, one cycle latency ----------------
    for (int i = 1; i <= 8; i++) begin
      vecs.push_back(mk($sformatf("stream%0d", i), 1, 16'(i), 32'(i), 0, 0, 1,
                        1, 16'(i), 32'(i), 2'd1, 1));
    end
    vecs.push_back(mk("stream_end", 0, 16'h0, 32'h0, 0, 0, 1,
                      0, 16'h0, 32'h8, 2'd0, 1));

    // ---------------- backpressure: A, B held, C refused ----------------
    vecs.push_back(mk("bp_pushA", 1, 16'h000A, 32'hA, 0, 0, 0, 1, 16'h000A, 32'hA, 2'd1, 1));
    vecs.push_back(mk("bp_pushB", 1, 16'h000B, 32'hB, 0, 0, 0, 1, 16'h000A, 32'hA, 2'd2, 0));
    vecs.push_back(mk("bp_refC",  1, 16'h000C, 32'hC, 0, 0, 0, 1, 16'h000A, 32'hA, 2'd2, 0));
    vecs.push_back(mk("bp_outB",  1, 16'h000C, 32'hC, 0, 0, 1, 1, 16'h000B, 32'hB, 2'd1, 1));
    vecs.push_back(mk("bp_outC",  1, 16'h000C, 32'hC, 0, 0, 1, 1, 16'h000C, 32'hC, 2'd1, 1));
    vecs.push_back(mk("bp_empty", 0, 16'h0,    32'h0, 0, 0, 1, 0, 16'h0,    32'hC, 2'd0, 1));

    // ---------------- hold with FULL ----------------
    vecs.push_back(mk("hd_push1", 1, 16'h0011, 32'h11, 0, 0, 0, 1, 16'h0011, 32'h11, 2'd1, 1));
    vecs.push_back(mk("hd_push2", 1, 16'h0022, 32'h22, 0, 0, 0, 1, 16'h0011, 32'h11, 2'd2, 0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk($sformatf("hd_frozen%0d", i), 0, 16'h0, 32'h0, 0, 1, 1,
                        1, 16'h0011, 32'h11, 2'd2, 0));
    end
    vecs.push_back(mk("hd_rel_B", 0, 16'h0, 32'h0, 0, 0, 1, 1, 16'h0022, 32'h22, 2'd1, 1));
    vecs.push_back(mk("hd_empty", 0, 16'h0, 32'h0, 0, 0, 1, 0, 16'h0,    32'h22, 2'd0, 1));

    // ---------------- flush with FULL and a same-cycle input ----------------
    vecs.push_back(mk("fl_push1", 1, 16'h0033, 32'h33, 0, 0, 0, 1, 16'h0033, 32'h33, 2'd1, 1));
    vecs.push_back(mk("fl_push2", 1, 16'h0044, 32'h44, 0, 0, 0, 1, 16'h0033, 32'h33, 2'd2, 0));
    vecs.push_back(mk("fl_flush", 1, 16'hFFFF, 32'h55, 1, 0, 0, 0, 16'h0,    32'h33, 2'd0, 1));
    vecs.push_back(mk("fl_idle",  0, 16'h0,    32'h0,  0, 0, 1, 0, 16'h0,    32'h33, 2'd0, 1));
    vecs.push_back(mk("fl_next",  1, 16'h0066, 32'h66, 0, 0, 0, 1, 16'h0066, 32'h66, 2'd1, 1));
    // Flush while ONE with a same-cycle drain and input: everything goes.
    vecs.push_back(mk("fl_drain", 1, 16'h0077, 32'h77, 1, 0, 1, 0, 16'h0,    32'h66, 2'd0, 1));

    // ---------------- refill to FULL ahead of async reset ----------------
    vecs.push_back(mk("rm_push1", 1, 16'h0081, 32'h81, 0, 0, 0, 1, 16'h0081, 32'h81, 2'd1, 1));
    vecs.push_back(mk("rm_push2", 1, 16'h0082, 32'h82, 0, 0, 0, 1, 16'h0081, 32'h81, 2'd2, 0));

    foreach (vecs[i]) step(vecs[i]);

    // ---------------- async reset mid-operation ----------------
    // Now 1 unit past a rising edge; reset must act without any clock edge.
    drive(1'b1, 16'h00AA, 32'hAA, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check("arst.out_valid", 256'(out_valid), 256'(0));
    check("arst.out_ctrl",  256'(out_ctrl),  256'(0));
    check("arst.out_data",  256'(out_data),  256'(0));
    check("arst.occupancy", 256'(occupancy), 256'(0));
    check("arst.in_ready",  256'(in_ready),  256'(1));
    check("arst.stall_cnt", 256'(stall_cnt), 256'(0));
    check("arst.bubble_cnt",256'(bubble_cnt),256'(0));
    @(posedge CLK);
    #1;
    check("arst.hold_occ",  256'(occupancy), 256'(0));
    RST = 1'b0;

    // ---------------- perf counters (counting starts at reset release) ------
    // 3 idle edges, 1 loading edge (still a bubble), 4 stalled edges, then a
    // flush that drains the head (neither a stall nor a bubble edge).
    for (int i = 0; i < 3; i++) begin
      step(mk($sformatf("pf_idle%0d", i), 0, 16'h0, 32'h0, 0, 0, 1,
              0, 16'h0, 32'h0, 2'd0, 1));
    end
    step(mk("pf_load", 1, 16'h0091, 32'h91, 0, 0, 0, 1, 16'h0091, 32'h91, 2'd1, 1));
    for (int i = 0; i < 4; i++) begin
      step(mk($sformatf("pf_stall%0d", i), 0, 16'h0, 32'h0, 0, 0, 0,
              1, 16'h0091, 32'h91, 2'd1, 1));
    end
`ifdef PIPE_STAGE_BUF_PERF_EN
    check("pf.stall_cnt",  256'(stall_cnt),  256'(4));
    check("pf.bubble_cnt", 256'(bubble_cnt), 256'(4));
`else
    check("pf.stall_cnt_tied",  256'(stall_cnt),  256'(0));
    check("pf.bubble_cnt_tied", 256'(bubble_cnt), 256'(0));
`endif
    step(mk("pf_flush", 0, 16'h0, 32'h0, 1, 0, 1, 0, 16'h0, 32'h91, 2'd0, 1));
`ifdef PIPE_STAGE_BUF_PERF_EN
    check("pf.flush_stall",  256'(stall_cnt),  256'(4));
    check("pf.flush_bubble", 256'(bubble_cnt), 256'(4));
    // A hold cycle with out_ready high still counts as a stall.
    step(mk("pf_reload", 1, 16'h0092, 32'h92, 0, 0, 0, 1, 16'h0092, 32'h92, 2'd1, 1));
    step(mk("pf_hold",   0, 16'h0,    32'h0,  0, 1, 1, 1, 16'h0092, 32'h92, 2'd1, 1));
    check("pf.hold_stall",  256'(stall_cnt),  256'(5));
    check("pf.hold_bubble", 256'(bubble_cnt), 256'(5));
`else
    check("pf.flush_stall_tied",  256'(stall_cnt),  256'(0));
    check("pf.flush_bubble_tied", 256'(bubble_cnt), 256'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
